// File: rtl/config_loader.sv
// Bit-serial configuration loader.
// Collects an LSB-first serial bitstream over a valid/ready handshake into
// WORD_W-bit words. Each word is presented to a bank of level-sensitive
// (transparent) latches and written with a one-cycle one-hot strobe. A
// SETUP cycle before the strobe and a HOLD cycle after it keep the latch
// data stable around the strobe.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 9
) (
    input  logic                 clk,
    input  logic                 reset,          // synchronous, active-low
    input  logic                 io_start,
    input  logic                 io_bit_in,
    input  logic                 io_bit_valid,
    output logic                 io_bit_ready,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WORD_W-1:0]    r_shift;
    logic [WORD_W-1:0]    r_d_out;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [IDX_W-1:0]     r_word_idx;
    logic [NUM_WORDS-1:0] r_configs_en;

    logic                 w_xfer;
    logic                 w_last_bit;
    logic                 w_last_word;
    logic                 w_idle_or_done;
    logic [WORD_W-1:0]    w_word;

    // Handshake and position decodes. Ready comes from state alone, so there
    // is no combinational path from io_bit_valid to io_bit_ready.
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_xfer         = (r_state == S_SHIFT) && io_bit_valid;
    assign w_last_bit     = (r_bit_cnt == LAST_BIT);
    assign w_last_word    = (r_word_idx == LAST_WORD);

    // Complete word as it will look once the final (MSB) bit is shifted in.
    always_comb begin
        w_word             = r_shift;
        w_word[WORD_W-1]   = io_bit_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next_state and
        // no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (io_start) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_xfer && w_last_bit) begin
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP:  w_next_state = S_STROBE;
            S_STROBE: w_next_state = S_HOLD;
            S_HOLD: begin
                w_next_state = w_last_word ? S_DONE : S_SHIFT;
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: bit assembly, word/bit counters, latch data and strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the shift register is cleared with everything else so an
            // abandoned partial word never reaches the latch data bus.
            r_shift      <= '0;
            r_d_out      <= '0;
            r_bit_cnt    <= '0;
            r_word_idx   <= '0;
            r_configs_en <= '0;
        end else begin
            // Strobe is a single registered pulse; it is 0 unless set below.
            r_configs_en <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_start) begin
                        r_word_idx <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_xfer) begin
                        r_shift[r_bit_cnt] <= io_bit_in;
                        if (w_last_bit) begin
                            // Word is presented during SETUP so it is stable a
                            // full cycle before, during and after the strobe.
                            r_d_out <= w_word;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    // Registered so the strobe is high exactly in STROBE.
                    r_configs_en <= NUM_WORDS'(1) << r_word_idx;
                end
                S_HOLD: begin
                    if (!w_last_word) begin
                        r_word_idx <= r_word_idx + 1'b1;
                        r_bit_cnt  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bit_ready  = (r_state == S_SHIFT);
    assign io_busy       = !w_idle_or_done;
    assign io_done       = (r_state == S_DONE);
    assign io_d_out      = r_d_out;
    assign io_configs_en = r_configs_en;

endmodule

// File: tb/tb_config_loader.sv
// Directed testbench for config_loader: full loads with and without valid
// gaps, strobe/data stability around every strobe, mid-load reset, ignored
// start requests and word-boundary handshake behaviour.
module tb_config_loader;

    localparam int WORD_W     = 32;
    localparam int NUM_WORDS  = 9;
    localparam int TOTAL_BITS = WORD_W * NUM_WORDS;
    localparam int LOAD_CYC   = NUM_WORDS * (WORD_W + 3);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 io_start;
    logic                 io_bit_in;
    logic                 io_bit_valid;
    logic                 io_bit_ready;
    logic [WORD_W-1:0]    io_d_out;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic                 io_busy;
    logic                 io_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0]    cur_words [NUM_WORDS];
    int                   exp_k;
    int                   bit_ptr;
    int                   low_run;
    bit                   feed_en;
    bit                   gap_mode;
    logic [WORD_W-1:0]    prev_d;
    logic [NUM_WORDS-1:0] prev_en;
    logic                 prev_ready;
    int                   cyc;

    always #5 clk = ~clk;

    config_loader #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_start     (io_start),
        .io_bit_in    (io_bit_in),
        .io_bit_valid (io_bit_valid),
        .io_bit_ready (io_bit_ready),
        .io_d_out     (io_d_out),
        .io_configs_en(io_configs_en),
        .io_busy      (io_busy),
        .io_done      (io_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sync_prev();
        prev_d     = io_d_out;
        prev_en    = io_configs_en;
        prev_ready = io_bit_ready;
        low_run    = 0;
    endtask

    // Per-cycle observation of the outputs, sampled on the falling edge.
    task automatic monitor();
        check("en_onehot", 32'($countones(io_configs_en) <= 1), 32'd1);
        if (prev_en != '0) begin
            check("hold_en_zero",   32'(io_configs_en), 32'd0);
            check("hold_d_stable",  io_d_out, prev_d);
            check("hold_ready_low", 32'(io_bit_ready), 32'd0);
        end
        if (io_configs_en != '0) begin
            if (exp_k < NUM_WORDS) begin
                check("strobe_en",   32'(io_configs_en), 32'(NUM_WORDS'(1) << exp_k));
                check("strobe_data", io_d_out, cur_words[exp_k]);
            end else begin
                check("strobe_extra", 32'(exp_k), 32'(NUM_WORDS - 1));
            end
            check("setup_d_stable",   io_d_out, prev_d);
            check("setup_en_zero",    32'(prev_en), 32'd0);
            check("setup_ready_low",  32'(prev_ready), 32'd0);
            check("strobe_ready_low", 32'(io_bit_ready), 32'd0);
            exp_k++;
        end
        if (io_busy && !io_bit_ready) begin
            low_run++;
        end else begin
            if (io_bit_ready && low_run > 0) begin
                check("gap_len", 32'(low_run), 32'd3);
            end
            low_run = 0;
        end
        prev_d     = io_d_out;
        prev_en    = io_configs_en;
        prev_ready = io_bit_ready;
    endtask

    // One clock: observe, drive inputs for the next rising edge, advance.
    task automatic tick(input logic start);
        logic rdy;
        logic v;
        monitor();
        rdy      = io_bit_ready;
        io_start = start;
        if (feed_en && bit_ptr < TOTAL_BITS) begin
            v            = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            io_bit_valid = v;
            io_bit_in    = cur_words[bit_ptr / WORD_W][bit_ptr % WORD_W];
            if (v && rdy) bit_ptr++;
        end else begin
            // Valid held high with junk outside a load: must never transfer.
            io_bit_valid = 1'b1;
            io_bit_in    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
    endtask

    task automatic run_load(input bit gaps, input bit inject, input int stop_k, output int ncyc);
        logic s;
        bit   hit_shift;
        bit   hit_strobe;
        bit   hit_hold;
        hit_shift  = 1'b0;
        hit_strobe = 1'b0;
        hit_hold   = 1'b0;
        exp_k      = 0;
        bit_ptr    = 0;
        low_run    = 0;
        gap_mode   = gaps;
        feed_en    = 1'b1;
        tick(1'b1);
        check("start_busy",     32'(io_busy), 32'd1);
        check("start_done_clr", 32'(io_done), 32'd0);
        ncyc = 0;
        while (!io_done && ncyc < 3000 && exp_k < stop_k) begin
            s = 1'b0;
            if (inject) begin
                if (!hit_shift && exp_k == 2 && io_bit_ready) begin
                    s = 1'b1;
                    hit_shift = 1'b1;
                end
                if (!hit_strobe && exp_k == 5 && io_configs_en != '0) begin
                    s = 1'b1;
                    hit_strobe = 1'b1;
                end
                if (!hit_hold && io_configs_en == '0 && prev_en == NUM_WORDS'(1) << (NUM_WORDS - 1)) begin
                    s = 1'b1;
                    hit_hold = 1'b1;
                end
            end
            tick(s);
            ncyc++;
        end
        io_start = 1'b0;
        feed_en  = 1'b0;
        if (ncyc >= 3000) check("load_timeout", 32'(ncyc), 32'(LOAD_CYC));
    endtask

    task automatic do_reset(input int ncyc);
        feed_en      = 1'b0;
        reset        = 1'b0;
        io_start     = 1'b0;
        io_bit_valid = 1'b0;
        io_bit_in    = 1'b0;
        repeat (ncyc) @(negedge clk);
        check("rst_d_out", io_d_out, 32'd0);
        check("rst_en",    32'(io_configs_en), 32'd0);
        check("rst_ready", 32'(io_bit_ready), 32'd0);
        check("rst_busy",  32'(io_busy), 32'd0);
        check("rst_done",  32'(io_done), 32'd0);
        reset = 1'b1;
        sync_prev();
    endtask

    initial begin
        io_start     = 1'b0;
        io_bit_in    = 1'b0;
        io_bit_valid = 1'b0;
        reset        = 1'b0;
        feed_en      = 1'b0;
        gap_mode     = 1'b0;
        bit_ptr      = 0;
        exp_k        = 0;
        low_run      = 0;
        for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = 32'hA500_0000 | 32'(k);

        // Reset state.
        @(negedge clk);
        do_reset(2);

        // 1: full load, valid always high.
        run_load(1'b0, 1'b0, NUM_WORDS + 1, cyc);
        check("t1_done_cycle", 32'(cyc), 32'(LOAD_CYC));
        check("t1_strobes",    32'(exp_k), 32'(NUM_WORDS));
        check("t1_bits",       32'(bit_ptr), 32'(TOTAL_BITS));
        repeat (3) tick(1'b0);
        check("t1_done_held",  32'(io_done), 32'd1);
        check("t1_idle_busy",  32'(io_busy), 32'd0);
        check("t1_last_word",  io_d_out, 32'hA500_0008);
        check("t1_no_extra",   32'(exp_k), 32'(NUM_WORDS));

        // 2: random valid gaps.
        run_load(1'b1, 1'b0, NUM_WORDS + 1, cyc);
        check("t2_min_cycles", 32'(cyc >= LOAD_CYC), 32'd1);
        check("t2_strobes",    32'(exp_k), 32'(NUM_WORDS));
        check("t2_bits",       32'(bit_ptr), 32'(TOTAL_BITS));
        check("t2_done",       32'(io_done), 32'd1);

        // 4: reset right after word 3 strobe, then reload with all ones.
        run_load(1'b0, 1'b0, 4, cyc);
        check("t4_stop_k", 32'(exp_k), 32'd4);
        do_reset(1);
        for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = 32'hFFFF_FFFF;
        run_load(1'b0, 1'b0, NUM_WORDS + 1, cyc);
        check("t4_done_cycle", 32'(cyc), 32'(LOAD_CYC));
        check("t4_strobes",    32'(exp_k), 32'(NUM_WORDS));
        check("t4_last_word",  io_d_out, 32'hFFFF_FFFF);

        // 5: start pulsed in SHIFT, STROBE and final HOLD is ignored.
        for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = 32'hA500_0000 | 32'(k);
        run_load(1'b0, 1'b1, NUM_WORDS + 1, cyc);
        check("t5_done_cycle", 32'(cyc), 32'(LOAD_CYC));
        check("t5_strobes",    32'(exp_k), 32'(NUM_WORDS));
        tick(1'b0);
        check("t5_done_held",  32'(io_done), 32'd1);
        check("t5_not_busy",   32'(io_busy), 32'd0);
        // Start from DONE reloads from word 0 (done clear checked in run_load).
        run_load(1'b0, 1'b0, NUM_WORDS + 1, cyc);
        check("t5_reload_cycle", 32'(cyc), 32'(LOAD_CYC));
        check("t5_reload_strobes", 32'(exp_k), 32'(NUM_WORDS));
        repeat (2) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
